// File: rtl/mem_wb_pipe_reg.sv
// mem_wb_pipe_reg: MEM/WB stage register with valid/ready handshake, optional skid entry,
// synchronous flush and a registered-head writeback-data mux.
module mem_wb_pipe_reg #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int SKID_EN = 1
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              inValid,
    output logic              inReady,
    input  logic [DATA_W-1:0] readData,
    input  logic [DATA_W-1:0] aluResult,
    input  logic [REG_W-1:0]  writeReg,
    input  logic              regWrite,
    input  logic              memToReg,
    input  logic              flush,
    output logic              outValid,
    input  logic              outReady,
    output logic [DATA_W-1:0] outReadData,
    output logic [DATA_W-1:0] outAluResult,
    output logic [REG_W-1:0]  outWriteReg,
    output logic              outRegWrite,
    output logic              outMemToReg,
    output logic [DATA_W-1:0] writeData
);
    typedef struct packed {
        logic [DATA_W-1:0] rd;
        logic [DATA_W-1:0] alu;
        logic [REG_W-1:0]  wr;
        logic              rw;
        logic              m2r;
    } entry_t;
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    state_t state, state_n;
    entry_t head, skid, in_entry;
    logic   in_xfer, out_xfer, ld_in, ld_skid, ld_from_skid;
    assign in_entry     = {readData, aluResult, writeReg, regWrite, memToReg};
    assign outValid     = state != EMPTY;
    // With the skid entry, inReady depends only on registered state.
    assign inReady      = (SKID_EN != 0) ? state != FULL : (!outValid || outReady);
    assign in_xfer      = inValid && inReady;
    assign out_xfer     = outValid && outReady;
    assign outReadData  = head.rd;
    assign outAluResult = head.alu;
    assign outWriteReg  = head.wr;
    assign outMemToReg  = head.m2r;
    assign outRegWrite  = head.rw && outValid;
    assign writeData    = head.m2r ? head.rd : head.alu;
    always_comb begin
        state_n      = state;
        ld_in        = 1'b0;
        ld_skid      = 1'b0;
        ld_from_skid = 1'b0;
        if (flush) state_n = EMPTY;
        else begin
            case (state)
                EMPTY: if (in_xfer) begin
                    state_n = ONE;
                    ld_in   = 1'b1;
                end
                ONE: begin
                    if (in_xfer && out_xfer) ld_in = 1'b1;
                    else if (in_xfer) begin
                        state_n = FULL;
                        ld_skid = 1'b1;
                    end else if (out_xfer) state_n = EMPTY;
                end
                FULL: if (out_xfer) begin
                    state_n      = ONE;
                    ld_from_skid = 1'b1;
                end
                default: state_n = EMPTY;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= EMPTY;
            head  <= '0;
            skid  <= '0;
        end else begin
            state <= state_n;
            if (flush) begin
                head.rw <= 1'b0;
                skid.rw <= 1'b0;
            end else begin
                if (ld_in) head <= in_entry;
                if (ld_from_skid) head <= skid;
                if (ld_skid) skid <= in_entry;
            end
        end
    end
endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// tb_mem_wb_pipe_reg: checks skid (SKID_EN=1) and single-entry (SKID_EN=0) instances
// against a FIFO-level model plus directed literal expectations.
module tb_mem_wb_pipe_reg;
    typedef struct packed {
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wr;
        logic        rw;
        logic        m2r;
    } ent_t;

    logic        clk = 0, rstN = 0;
    logic        inValid = 0, regWrite = 0, memToReg = 0, flush = 0, outReady = 1;
    logic [31:0] readData = 0, aluResult = 0;
    logic [4:0]  writeReg = 0;

    logic        s1_in_ready, s1_out_valid, s1_rw, s1_m2r;
    logic [31:0] s1_rd, s1_alu, s1_wd;
    logic [4:0]  s1_wr;
    logic        s0_in_ready, s0_out_valid, s0_rw, s0_m2r;
    logic [31:0] s0_rd, s0_alu, s0_wd;
    logic [4:0]  s0_wr;

    int errs = 0, checks = 0;
    ent_t q1[$], q0[$];

    always #5 clk = ~clk;

    mem_wb_pipe_reg #(.DATA_W(32), .REG_W(5), .SKID_EN(1)) d1 (
        .clk(clk), .rstN(rstN), .inValid(inValid), .inReady(s1_in_ready),
        .readData(readData), .aluResult(aluResult), .writeReg(writeReg),
        .regWrite(regWrite), .memToReg(memToReg), .flush(flush),
        .outValid(s1_out_valid), .outReady(outReady), .outReadData(s1_rd),
        .outAluResult(s1_alu), .outWriteReg(s1_wr), .outRegWrite(s1_rw),
        .outMemToReg(s1_m2r), .writeData(s1_wd)
    );

    mem_wb_pipe_reg #(.DATA_W(32), .REG_W(5), .SKID_EN(0)) d0 (
        .clk(clk), .rstN(rstN), .inValid(inValid), .inReady(s0_in_ready),
        .readData(readData), .aluResult(aluResult), .writeReg(writeReg),
        .regWrite(regWrite), .memToReg(memToReg), .flush(flush),
        .outValid(s0_out_valid), .outReady(outReady), .outReadData(s0_rd),
        .outAluResult(s0_alu), .outWriteReg(s0_wr), .outRegWrite(s0_rw),
        .outMemToReg(s0_m2r), .writeData(s0_wd)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Model: each instance is an in-order queue; capacity 2 with registered ready,
    // or capacity 1 whose ready also opens when the consumer takes the head.
    always @(posedge clk or negedge rstN) begin
        logic r1, r0;
        ent_t e;
        if (!rstN) begin
            q1.delete();
            q0.delete();
        end else begin
            e  = {readData, aluResult, writeReg, regWrite, memToReg};
            r1 = q1.size() < 2;
            r0 = q0.size() == 0 || outReady;
            if (flush) begin
                q1.delete();
                q0.delete();
            end else begin
                if (q1.size() != 0 && outReady) void'(q1.pop_front());
                if (inValid && r1) q1.push_back(e);
                if (q0.size() != 0 && outReady) void'(q0.pop_front());
                if (inValid && r0) q0.push_back(e);
            end
        end
    end

    task automatic check_dut(input string n, input ent_t q[$], input logic exp_rdy,
                             input logic rdy, input logic ov, input logic [31:0] wd,
                             input logic [4:0] wr, input logic [31:0] alu, input logic [31:0] rd,
                             input logic rw, input logic m2r);
        chk({n, ".inReady"}, rdy, exp_rdy);
        chk({n, ".outValid"}, ov, q.size() != 0);
        if (q.size() != 0) begin
            chk({n, ".writeData"}, wd, q[0].m2r ? q[0].rd : q[0].alu);
            chk({n, ".outWriteReg"}, wr, q[0].wr);
            chk({n, ".outAluResult"}, alu, q[0].alu);
            chk({n, ".outReadData"}, rd, q[0].rd);
            chk({n, ".outMemToReg"}, m2r, q[0].m2r);
            chk({n, ".outRegWrite"}, rw, q[0].rw);
        end else chk({n, ".outRegWrite_bubble"}, rw, 0);
    endtask

    always @(negedge clk) begin
        check_dut("skid", q1, q1.size() < 2, s1_in_ready, s1_out_valid, s1_wd, s1_wr,
                  s1_alu, s1_rd, s1_rw, s1_m2r);
        check_dut("single", q0, q0.size() == 0 || outReady, s0_in_ready, s0_out_valid,
                  s0_wd, s0_wr, s0_alu, s0_rd, s0_rw, s0_m2r);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] rd, input logic [31:0] alu,
                         input logic [4:0] wr, input logic rw, input logic m2r);
        inValid = v; readData = rd; aluResult = alu; writeReg = wr; regWrite = rw; memToReg = m2r;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", s1_out_valid, 0);
        chk("rst_in_ready", s1_in_ready, 1);
        chk("rst_write_data", s1_wd, 0);
        chk("rst_out_reg_write", s1_rw, 0);
        rstN = 1;
        // single op
        drive(1, 32'hDEADBEEF, 32'h10, 5'd8, 1, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("single_valid", s1_out_valid, 1);
        chk("single_wd", s1_wd, 32'hDEADBEEF);
        chk("single_wr", s1_wr, 8);
        chk("single_rw", s1_rw, 1);
        chk("single_wd_s0", s0_wd, 32'hDEADBEEF);
        tick();
        chk("single_after_valid", s1_out_valid, 0);
        chk("single_after_rw", s1_rw, 0);
        // streaming
        for (int i = 1; i <= 8; i++) begin
            drive(1, 32'hFFFF0000, i, 5'(i), 1, 0);
            chk("stream_in_ready", s1_in_ready, 1);
            tick();
            chk("stream_wd", s1_wd, i);
            chk("stream_wd_s0", s0_wd, i);
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();
        // backpressure
        outReady = 0;
        drive(1, 0, 5, 5, 1, 0);
        tick();
        drive(1, 0, 6, 6, 1, 0);
        tick();
        chk("bp_in_ready_full", s1_in_ready, 0);
        chk("bp_head_a", s1_wd, 5);
        drive(1, 0, 7, 7, 1, 0);
        tick();
        chk("bp_hold_a", s1_wd, 5);
        chk("bp_hold_ready", s1_in_ready, 0);
        outReady = 1;
        tick();
        chk("bp_head_b", s1_wd, 6);
        chk("bp_ready_back", s1_in_ready, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("bp_head_c", s1_wd, 7);
        tick();
        chk("bp_drained", s1_out_valid, 0);
        // flush in FULL with an offered input
        outReady = 0;
        drive(1, 0, 5, 5, 1, 0);
        tick();
        drive(1, 0, 6, 6, 1, 0);
        tick();
        drive(1, 0, 9, 9, 1, 0);
        flush = 1;
        tick();
        flush = 0;
        drive(0, 0, 0, 0, 0, 0);
        chk("flush_valid", s1_out_valid, 0);
        chk("flush_rw", s1_rw, 0);
        chk("flush_ready", s1_in_ready, 1);
        // flush with one entry and an accepted input in the same cycle
        outReady = 1;
        drive(1, 0, 5, 5, 1, 0);
        tick();
        drive(1, 0, 9, 9, 1, 0);
        flush = 1;
        tick();
        flush = 0;
        drive(0, 0, 0, 0, 0, 0);
        chk("flush_xfer_valid", s1_out_valid, 0);
        chk("flush_xfer_valid_s0", s0_out_valid, 0);
        tick();
        chk("flush_no_9", s1_out_valid, 0);
        // async reset while stalled in FULL
        outReady = 0;
        drive(1, 0, 5, 5, 1, 0);
        tick();
        drive(1, 0, 6, 6, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #2 rstN = 0;
        #1;
        chk("areset_valid", s1_out_valid, 0);
        chk("areset_wd", s1_wd, 0);
        chk("areset_ready", s1_in_ready, 1);
        chk("areset_valid_s0", s0_out_valid, 0);
        tick();
        rstN = 1;
        // single-entry stall and same-edge replace
        drive(1, 0, 11, 11, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("s0_stall_valid", s0_out_valid, 1);
        chk("s0_stall_ready", s0_in_ready, 0);
        drive(1, 0, 12, 12, 1, 0);
        outReady = 1;
        #1;
        chk("s0_ready_comb", s0_in_ready, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("s0_replace_wd", s0_wd, 12);
        chk("s0_replace_valid", s0_out_valid, 1);
        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
